// File: rtl/alu_seq_top_if.sv
// Board-side bundle for alu_seq_top: switch/key inputs and display outputs.
// The master modport is the board (or bench) side; slave is the ALU top.
interface alu_seq_top_if #(
  parameter int WIDTH = 8
);
  localparam int NDIG = (WIDTH + 3) / 4;

  logic [9:0]          switches;
  logic                key_enter_n;
  logic                key_clear_n;
  logic [7*NDIG-1:0]   hex_n;
  logic [9:0]          leds;

  modport master (
    output switches, key_enter_n, key_clear_n,
    input  hex_n, leds
  );

  modport slave (
    input  switches, key_enter_n, key_clear_n,
    output hex_n, leds
  );
endinterface

// File: rtl/alu_seq_top.sv
// alu_seq_top: registered WIDTH-bit ALU with operands entered from switches
// via a debounced push-button FSM (LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> SHOW).
// Result is shown in hex on seven-segment digits; flags and state on LEDs.
// Optional feature macro: ALU_CHAIN_EN (SHOW + enter loads A = Y, goes to LOAD_B).

// Synchroniser + debouncer for one active-low key; emits a 1-cycle pulse on
// the accepted press (high-to-low) only.
module alu_seq_key #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    sync_d   = {sync_q[0], key_n};
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_q[1];
        press_d  = stable_q & ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Key state registers; released (high) is the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
endmodule

module alu_seq_top #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_top_if.slave bus
);
  localparam int NDIG = (WIDTH + 3) / 4;
  localparam int SW   = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [2:0] {
    LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_ASR = 3'd7
  } op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  // ---------------------------------------------------------------- inputs
  logic [WIDTH-1:0] sw_meta_q, sw_meta_d, sw_q, sw_d;
  logic             sw_unused;
  logic             enter, clear;

  assign sw_unused = ^bus.switches[9:WIDTH];

  // Switch synchroniser next values.
  always_comb begin
    sw_meta_d = bus.switches[WIDTH-1:0];
    sw_d      = sw_meta_q;
  end

  // Switch synchroniser; pure data path that follows the pins within two clocks.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose -- the display must track live switches even while rst_n is low.
    sw_meta_q <= sw_meta_d;
    sw_q      <= sw_d;
  end

  alu_seq_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_enter_n), .press(enter)
  );

  alu_seq_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_clear_n), .press(clear)
  );

  // ---------------------------------------------------------------- ALU
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  op_e              op_q, op_d;
  flags_t           flags_q, flags_d;

  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_y;
  flags_t           alu_f;

  assign shamt = b_q[SW-1:0];

  // Combinational ALU on the captured operands; sampled into Y/flags in EXEC.
  always_comb begin
    wide    = '0;
    alu_y   = '0;
    alu_f   = '0;
    unique case (op_q)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_y   = wide[WIDTH-1:0];
        alu_f.c = wide[WIDTH];
        alu_f.v = (a_q[MSB] == b_q[MSB]) && (alu_y[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_y   = a_q - b_q;
        alu_f.c = (a_q >= b_q);
        alu_f.v = (a_q[MSB] != b_q[MSB]) && (alu_y[MSB] != a_q[MSB]);
      end
      OP_AND: alu_y = a_q & b_q;
      OP_OR:  alu_y = a_q | b_q;
      OP_XOR: alu_y = a_q ^ b_q;
      OP_SHL: begin
        // Extra top bit catches the last bit shifted out (0 when s = 0).
        wide    = {1'b0, a_q} << shamt;
        alu_y   = wide[WIDTH-1:0];
        alu_f.c = wide[WIDTH];
      end
      OP_SHR: begin
        // Extra bottom bit catches A[s-1] (0 when s = 0).
        wide    = {a_q, 1'b0} >> shamt;
        alu_y   = wide[WIDTH:1];
        alu_f.c = wide[0];
      end
      OP_ASR: begin
        wide    = $unsigned($signed({a_q, 1'b0}) >>> shamt);
        alu_y   = wide[WIDTH:1];
        alu_f.c = wide[0];
      end
    endcase
    alu_f.z = (alu_y == '0);
    alu_f.n = alu_y[MSB];
  end

  // ---------------------------------------------------------------- FSM
  // Next state and register updates; clear overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    flags_d = flags_q;
    if (clear) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = OP_ADD;
      y_d     = '0;
      flags_d = '0;
    end else begin
      unique case (state_q)
        LOAD_A: if (enter) begin
          a_d     = sw_q;
          state_d = LOAD_B;
        end
        LOAD_B: if (enter) begin
          b_d     = sw_q;
          state_d = LOAD_OP;
        end
        LOAD_OP: if (enter) begin
          op_d    = op_e'(sw_q[2:0]);
          state_d = EXEC;
        end
        EXEC: begin
          // Enter is ignored here; the single EXEC cycle always completes.
          y_d     = alu_y;
          flags_d = alu_f;
          state_d = SHOW;
        end
        SHOW: if (enter) begin
`ifdef ALU_CHAIN_EN
          a_d     = y_q;
          state_d = LOAD_B;
`else
          state_d = LOAD_A;
`endif
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  // ---------------------------------------------------------------- display
  logic [4*NDIG-1:0] disp;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    unique case (nib)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Select what the digits show: live switches while loading, Y afterwards.
  always_comb begin
    disp = '0;
    unique case (state_q)
      LOAD_A, LOAD_B: disp[WIDTH-1:0] = sw_q;
      LOAD_OP:        disp[2:0]       = sw_q[2:0];
      default:        disp[WIDTH-1:0] = y_q;
    endcase
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    assign bus.hex_n[7*k +: 7] = seg7(disp[4*k +: 4]);
  end

  assign bus.leds = {2'b00,
                     state_q == SHOW, state_q == LOAD_OP,
                     state_q == LOAD_B, state_q == LOAD_A,
                     flags_q};
endmodule

// File: tb/tb_alu_seq_top.sv
// Self-checking bench for alu_seq_top (WIDTH=8, DEBOUNCE_CYCLES=4): directed
// test-plan steps plus random operations against a plain-arithmetic model.
module tb_alu_seq_top;
  localparam int WIDTH = 8;
  localparam int DB    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_top_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_top #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Expected-state model: one-hot {SHOW,LOAD_OP,LOAD_B,LOAD_A}.
  localparam logic [3:0] ST_A = 4'b0001, ST_B = 4'b0010, ST_OP = 4'b0100, ST_SHOW = 4'b1000;
  logic [3:0] exp_st;
  logic [3:0] exp_flags;   // {V,C,N,Z}
  int         exp_y, exp_a, exp_sw;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [13:0] exp_hex(input int v);
    return {SEG[(v >> 4) & 15], SEG[v & 15]};
  endfunction

  // Reference ALU: returns {V,C,N,Z, Y[7:0]} from integer arithmetic.
  function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
    int y, c, v, sa, sb, sr, s;
    c  = 0; v = 0; y = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s  = b % 8;
    case (op)
      0: begin y = (a + b) % 256; c = (a + b >= 256); sr = sa + sb; v = (sr > 127 || sr < -128); end
      1: begin y = (a - b + 256) % 256; c = (a >= b); sr = sa - sb; v = (sr > 127 || sr < -128); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin y = (a * (1 << s)) % 256; c = (s == 0) ? 0 : (a >> (8 - s)) & 1; end
      6: begin y = a / (1 << s);         c = (s == 0) ? 0 : (a >> (s - 1)) & 1; end
      default: begin y = (sa >>> s) & 255; c = (s == 0) ? 0 : (a >> (s - 1)) & 1; end
    endcase
    return {v[0], c[0], (y >= 128), (y == 0), y[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int shown;
    if (exp_st == ST_SHOW)    shown = exp_y;
    else if (exp_st == ST_OP) shown = exp_sw & 7;
    else                      shown = exp_sw & 255;
    check({tag, "_hex"}, 32'(bus.hex_n), 32'(exp_hex(shown)));
    check({tag, "_leds"}, 32'(bus.leds), 32'({2'b00, exp_st, exp_flags}));
  endtask

  task automatic set_sw(input int v);
    bus.switches = 10'(v);
    exp_sw = v;
  endtask

  // which: 0 = enter, 1 = clear, 2 = both together.
  task automatic press(input int which);
    if (which != 1) bus.key_enter_n = 1'b0;
    if (which != 0) bus.key_clear_n = 1'b0;
    repeat (12) @(posedge clk);
    bus.key_enter_n = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    exp_st = ST_A; exp_flags = 4'h0; exp_y = 0; exp_a = 0;
  endtask

  task automatic do_op(input int a, input int b, input int op, input string tag);
    logic [11:0] r;
    set_sw(a);  press(0); exp_a = a; exp_st = ST_B;  check_outputs({tag, "_a"});
    set_sw(b);  press(0); exp_st = ST_OP;            check_outputs({tag, "_b"});
    set_sw(op); press(0);
    r = ref_alu(exp_a, b, op);
    exp_y = int'(r[7:0]); exp_flags = r[11:8]; exp_st = ST_SHOW;
    check_outputs({tag, "_show"});
  endtask

  task automatic leave_show(input string tag);
    press(0);
`ifdef ALU_CHAIN_EN
    exp_a = exp_y; exp_st = ST_B;
    check_outputs(tag);
    press(1); clear_model();
    check_outputs({tag, "_clr"});
`else
    exp_st = ST_A;
    check_outputs(tag);
`endif
  endtask

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exec_seen;
    logic [11:0] r;

    // Reset: display follows live switches, leds show LOAD_A only.
    rst_n = 1'b0;
    bus.key_enter_n = 1'b1;
    bus.key_clear_n = 1'b1;
    set_sw(10'h03C);
    clear_model();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_leds", 32'(bus.leds), 32'h010);
    check("rst_hex", 32'(bus.hex_n), 32'(exp_hex(8'h3C)));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst");

    // Signed overflow on ADD.
    do_op(8'h7F, 8'h01, 0, "add_ovf");
    check("add_ovf_y", 32'(bus.hex_n), 32'(exp_hex(8'h80)));
    check("add_ovf_flags", 32'(bus.leds[7:0]), 32'h8A);
    leave_show("add_ovf_leave");

    // SUB: equal operands and borrow.
    do_op(8'h05, 8'h05, 1, "sub_eq");
    check("sub_eq_flags", 32'(bus.leds[3:0]), 32'h5);
    leave_show("sub_eq_leave");
    do_op(8'h03, 8'h05, 1, "sub_borrow");
    check("sub_borrow_y", 32'(bus.hex_n), 32'(exp_hex(8'hFE)));
    leave_show("sub_borrow_leave");

    // Logical vs arithmetic right shift.
    do_op(8'h81, 8'h01, 6, "shr");
    check("shr_y", 32'(bus.hex_n), 32'(exp_hex(8'h40)));
    leave_show("shr_leave");
    do_op(8'h81, 8'h01, 7, "asr");
    check("asr_y", 32'(bus.hex_n), 32'(exp_hex(8'hC0)));
    check("asr_flags", 32'(bus.leds[3:0]), 32'h6);
    leave_show("asr_leave");

    // Short glitch on enter: no state change.
    set_sw(8'h5A);
    bus.key_enter_n = 1'b0;
    repeat (2) @(posedge clk);
    bus.key_enter_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_outputs("glitch");

    // Long hold: exactly one advance.
    bus.key_enter_n = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    exp_a = 8'h5A; exp_st = ST_B;
    check_outputs("hold_low");
    bus.key_enter_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_outputs("hold_release");

    // Clear from LOAD_OP zeroes flags and returns to LOAD_A.
    set_sw(8'h02); press(0); exp_st = ST_OP;
    check_outputs("to_load_op");
    press(1); clear_model();
    check("clear_op_leds", 32'(bus.leds), 32'h010);
    check_outputs("clear_op");

    // Enter and clear together: clear wins.
    set_sw(8'h11); press(0); exp_st = ST_B;
    check_outputs("pre_both");
    press(2); clear_model();
    check_outputs("both_keys");

    // Reset asserted during the single EXEC cycle.
    set_sw(8'hFF); press(0); exp_st = ST_B;
    set_sw(8'h01); press(0); exp_st = ST_OP;
    set_sw(0);
    exec_seen = 1'b0;
    bus.key_enter_n = 1'b0;
    for (int i = 0; i < 30 && !exec_seen; i++) begin
      @(negedge clk);
      if (bus.leds[7:4] == 4'b0000) exec_seen = 1'b1;
    end
    check("exec_seen", 32'(exec_seen), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_exec_leds", 32'(bus.leds), 32'h010);
    check("rst_exec_hex", 32'(bus.hex_n), 32'(exp_hex(0)));
    bus.key_enter_n = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    clear_model();
    check_outputs("post_rst_exec");

    // Accumulator chaining (or plain return to LOAD_A without it).
    do_op(8'h10, 8'h20, 0, "chain1");
    check("chain1_y", 32'(bus.hex_n), 32'(exp_hex(8'h30)));
`ifdef ALU_CHAIN_EN
    press(0); exp_a = exp_y; exp_st = ST_B;
    check_outputs("chain_to_b");
    set_sw(8'h05); press(0); exp_st = ST_OP;
    set_sw(0); press(0);
    r = ref_alu(exp_a, 8'h05, 0);
    exp_y = int'(r[7:0]); exp_flags = r[11:8]; exp_st = ST_SHOW;
    check_outputs("chain2");
    check("chain2_y", 32'(bus.hex_n), 32'(exp_hex(8'h35)));
    press(1); clear_model();
    check_outputs("chain_clr");
`else
    leave_show("nochain_leave");
    check("nochain_state", 32'(bus.leds[7:4]), 32'h1);
`endif

    // Random operations against the model.
    for (int i = 0; i < 16; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), "rnd");
      leave_show("rnd_leave");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
Second-generation ALU board top: a registered, WIDTH-bit ALU with sequential operand entry from switches through a debounced push-button FSM.
- Result and Z/N/C/V flags are held in registers.
- The result is shown in hex on ceil(WIDTH/4) seven-segment digits.
- Flags and FSM state are shown on LEDs.
- Sits directly under the board pin-out, replacing the purely combinational switch-to-ALU top.

Parameters:
WIDTH, 8, operand/result width; legal range 4..8; switches[WIDTH-1:0] carry operand entry.
DEBOUNCE_CYCLES, 50000, clk cycles a synchronised key level must be stable before acceptance; set to 4 in simulation.
NDIG (localparam), (WIDTH+3)/4, number of hex digits driven.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
switches  input  10  operand/opcode entry; asynchronous, double-flop synchronised internally
key_enter_n  input  1  push button, active-low; press advances the FSM
key_clear_n  input  1  push button, active-low; press aborts to LOAD_A
hex_n  output  7*NDIG  seven-seg digits, active-low segments {g..a}; digit k = bits [7k+6:7k], digit 0 = least significant nibble
leds  output  10  [0]=Z [1]=N [2]=C [3]=V; [7:4] one-hot state {SHOW,LOAD_OP,LOAD_B,LOAD_A}; [9:8]=0

Behaviour:
Reset (rst_n low, async):
- State = LOAD_A; registers A, B, OP, Y and flags all = 0.
- leds = 10'b0000010000; hex_n shows the live switch value.

Key path, per key:
- 2-FF synchroniser, then a debounce counter (must see DEBOUNCE_CYCLES equal consecutive samples).
- A 1-cycle press pulse fires on the accepted high-to-low transition only; holding the key gives exactly one pulse.

FSM:
- LOAD_A: enter pulse captures A = switches[WIDTH-1:0] -> LOAD_B.
- LOAD_B: enter captures B -> LOAD_OP.
- LOAD_OP: enter captures OP = switches[2:0] -> EXEC.
- EXEC: single cycle; registers Y and flags -> SHOW. Result is visible on the cycle after EXEC (1-cycle latency).
- SHOW: enter -> LOAD_A; A, B, Y and flags retained until overwritten.
- Clear pulse in any state: -> LOAD_A and zero A, B, OP, Y, flags.
- Clear and enter pulses in the same cycle: clear wins.
- Enter pulses arriving during EXEC are dropped.

Display:
- In LOAD_A and LOAD_B: live synchronised switches[WIDTH-1:0].
- In LOAD_OP: live switches[2:0], zero-extended.
- In EXEC and SHOW: Y.
- Hex glyphs 0-F, standard DE-series encoding.
- leds[3:0] always reflect the flag registers.

Operations (OP), all modulo 2^WIDTH; shift amount s = B[$clog2(WIDTH)-1:0]:
- 000 ADD: C = carry out; V = signed overflow.
- 001 SUB (A-B): C = 1 when A >= B unsigned (no borrow); V = signed overflow.
- 010 AND, 011 OR, 100 XOR: C = V = 0.
- 101 SHL: C = last bit shifted out (A[WIDTH-s]), 0 if s = 0.
- 110 SHR: C = A[s-1], 0 if s = 0.
- 111 ASR: sign fill; C = A[s-1], 0 if s = 0.
- All shifts: V = 0.
- All ops: Z = (Y == 0); N = Y[WIDTH-1].

Optional Feature:
Macro ALU_CHAIN_EN.
- Defined: in SHOW, an enter pulse loads A = Y and goes to LOAD_B, giving accumulator chaining. Flags stay visible until the next EXEC. Clear still returns to LOAD_A with all registers zeroed.
- Undefined: SHOW -> LOAD_A as specified above; no chaining logic synthesised.

Test Plan:
1. WIDTH=8, DEBOUNCE_CYCLES=4; enter A=0x7F, B=0x01, OP=000 -> SHOW: Y=0x80, hex_n shows "80", leds[3:0]=4'b1010 (V=1, N=1, C=0, Z=0), leds[7:4]=4'b1000.
2. A=0x05, B=0x05, OP=001 -> Y=0x00; Z=1, C=1, N=0, V=0. Then A=0x03, B=0x05, SUB -> Y=0xFE; C=0, N=1.
3. A=0x81, B=0x01, OP=110 -> Y=0x40, C=1. Same operands with OP=111 -> Y=0xC0, C=1, N=1.
4. Enter key low for 2 cycles then high (shorter than debounce) -> no state change. Key held low for 100 cycles -> exactly one advance.
5. Clear pulse in LOAD_OP -> LOAD_A, leds=10'b0000010000. Enter and clear in the same cycle -> LOAD_A. rst_n asserted mid-EXEC -> immediate reset values.
6. ALU_CHAIN_EN defined: ADD 0x10+0x20 -> Y=0x30. Enter -> LOAD_B with A=0x30; B=0x05, ADD -> Y=0x35. Undefined: enter from SHOW -> LOAD_A.
